// File: rtl/load_store_unit.sv
// load_store_unit
//   Accepts one load/store at a time from the execute stage, issues a single
//   request on the data-memory channel, collects the load response, and
//   reports the result for one cycle on the writeback port.
//
//   Optional build macro: MISALIGNED_TRAP_EN
//     defined   : misaligned halfword/word accesses skip memory and report fault
//     undefined : misaligned accesses are force-aligned, fault stays 0
//
//   Ports
//     clk, reset_n            clock, synchronous active-low reset
//     ex_valid/ex_ready       request handshake from execute
//     ex_write/addr/wdata/trunc/rd   request payload (trunc: access size/sign)
//     mem_req/gnt/we/addr/be/wdata   data-memory request channel
//     mem_rvalid/rdata        data-memory load response
//     wb_valid/load/rd/data   one-cycle writeback result
//     fault, busy             misaligned trap flag, unit occupied
//
//   state | meaning
//   IDLE  | ready for a new request
//   REQ   | mem_req held until grant
//   WAIT  | load granted, waiting for rvalid
//   RESP  | wb_valid for one cycle
module load_store_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_trunc,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_load,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [2:0] T_BYTE   = 3'd0;
  localparam logic [2:0] T_HALF   = 3'd1;
  localparam logic [2:0] T_WORD   = 3'd2;
  localparam logic [2:0] T_BYTE_U = 3'd3;
  localparam logic [2:0] T_HALF_U = 3'd4;

  state_t      state, state_nxt;
  logic        write_q, fault_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [2:0]  trunc_q;
  logic [4:0]  rd_q;

  logic        accept, in_access, in_trap;
  logic [1:0]  lane;
  logic [31:0] shifted, load_ext, wdata_rep;
  logic [3:0]  be;

  assign accept    = (state == IDLE) && ex_valid;
  // NONE (and unused codes 6/7) complete without touching memory
  assign in_access = (ex_trunc <= T_HALF_U);

`ifdef MISALIGNED_TRAP_EN
  always_comb begin
    in_trap = 1'b0;
    case (ex_trunc)
      T_HALF, T_HALF_U: in_trap = ex_addr[0];
      T_WORD:           in_trap = |ex_addr[1:0];
      default:          in_trap = 1'b0;
    endcase
  end
`else
  assign in_trap = 1'b0;
`endif

  // Low address bits below the access size are dropped, which also force-aligns
  // misaligned accesses when they are not trapped.
  always_comb begin
    case (trunc_q)
      T_HALF, T_HALF_U: lane = {addr_q[1], 1'b0};
      T_WORD:           lane = 2'b00;
      default:          lane = addr_q[1:0];
    endcase
  end

  assign shifted = mem_rdata >> {lane, 3'b000};

  always_comb begin
    case (trunc_q)
      T_BYTE:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      T_HALF:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      T_BYTE_U: load_ext = {24'h0, shifted[7:0]};
      T_HALF_U: load_ext = {16'h0, shifted[15:0]};
      default:  load_ext = shifted;
    endcase
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_q;
    case (trunc_q)
      T_BYTE, T_BYTE_U: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      T_HALF, T_HALF_U: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      T_WORD:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ex_valid) state_nxt = (in_access && !in_trap) ? REQ : RESP;
      REQ:  if (mem_gnt) state_nxt = write_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      trunc_q <= 3'd0;
      rd_q    <= 5'd0;
      data_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        write_q <= ex_write;
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        trunc_q <= ex_trunc;
        rd_q    <= ex_rd;
        data_q  <= 32'h0;
        fault_q <= in_access && in_trap;
      end else if (state == WAIT && mem_rvalid) begin
        data_q <= load_ext;
      end
    end
  end

  // Outputs are gated by state so that everything reads as zero outside the
  // phase where it is meaningful, including right after reset.
  always_comb begin
    ex_ready  = (state == IDLE);
    busy      = (state != IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    wb_valid  = 1'b0;
    wb_load   = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'h0;
    fault     = 1'b0;
    if (state == REQ) begin
      mem_req   = 1'b1;
      mem_we    = write_q;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_be    = be;
      mem_wdata = wdata_rep;
    end
    if (state == RESP) begin
      wb_valid = 1'b1;
      wb_load  = !write_q;
      wb_rd    = rd_q;
      wb_data  = data_q;
      fault    = fault_q;
    end
  end

endmodule
